// File: rtl/rnn_accel.sv
// rnn_accel -- memory-mapped RNN cell accelerator.
//
// Computes h[r] = sat16(((sum_c W[r][c]*x[c]) >>> FRAC_BITS) + b[r]) using a
// single sequential multiply-accumulate unit. The host loads x, W and b over a
// simple 32-bit slave bus, writes CTRL to start, and polls STATUS for done.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   read     in   bus read strobe (registered read, 1-cycle latency)
//   write    in   bus write strobe (wins over read when both are high)
//   addr     in   word address, only addr[7:0] decoded
//   data_in  in   write data
//   data_out out  read data, holds between reads
//
// Write map: 0 CTRL (bit0 = start), 1 INPUT {idx,val}, 2 WEIGHT {row,col,val},
//            3 BIAS {idx,val}.
// Read map:  0 STATUS {30'b0,busy,done}, 16+i h[i] sign-extended, others 0.
//
// Optional build macro RNN_ACCEL_RELU_EN: when defined, write-back applies
// ReLU (max(0, saturated value)); register map and latency are unchanged.

module rnn_accel #(
  parameter int IN_DIM    = 4,
  parameter int HID_DIM   = 2,
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int COL_W = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
  localparam int ROW_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic signed [39:0]     acc_q, acc_d;
  logic                   done_q, done_d;
  logic [31:0]            data_out_q, data_out_d;

  logic signed [15:0]     x_q [IN_DIM];
  logic signed [15:0]     x_d [IN_DIM];
  logic signed [15:0]     w_q [HID_DIM][IN_DIM];
  logic signed [15:0]     w_d [HID_DIM][IN_DIM];
  logic signed [15:0]     b_q [HID_DIM];
  logic signed [15:0]     b_d [HID_DIM];
  logic signed [15:0]     h_q [HID_DIM];
  logic signed [15:0]     h_d [HID_DIM];

  logic                   busy;
  logic [7:0]             addr_lo;
  logic                   unused_addr_hi;
  logic signed [15:0]     w_cur, x_cur, b_cur;
  logic signed [31:0]     prod;
  logic signed [39:0]     acc_sh;
  logic signed [40:0]     wb_sum;
  logic signed [15:0]     wb_sat, wb_val;

  assign busy           = (state_q != ST_IDLE);
  assign addr_lo        = addr[7:0];
  assign unused_addr_hi = ^addr[31:8];
  assign data_out       = data_out_q;

  // MAC datapath operands for the current row/column.
  assign w_cur  = w_q[row_q][col_q];
  assign x_cur  = x_q[col_q];
  assign b_cur  = b_q[row_q];
  assign prod   = w_cur * x_cur;

  // Write-back: scale, add bias with one guard bit, then clamp to 16 bits.
  assign acc_sh = acc_q >>> FRAC_BITS;
  assign wb_sum = {acc_sh[39], acc_sh} + {{25{b_cur[15]}}, b_cur};

  always_comb begin
    wb_sat = wb_sum[15:0];
    if (wb_sum > 41'sd32767) begin
      wb_sat = 16'sh7FFF;
    end else if (wb_sum < -41'sd32768) begin
      wb_sat = 16'sh8000;
    end
`ifdef RNN_ACCEL_RELU_EN
    wb_val = wb_sat[15] ? 16'sd0 : wb_sat;
`else
    wb_val = wb_sat;
`endif
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    done_d     = done_q;
    data_out_d = data_out_q;
    x_d        = x_q;
    w_d        = w_q;
    b_d        = b_q;
    h_d        = h_q;

    // Bus writes: configuration and start only accepted while idle.
    if (write && !busy) begin
      case (addr_lo)
        8'd0: begin
          if (data_in[0]) begin
            state_d = ST_MAC;
            done_d  = 1'b0;
            acc_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end
        end
        8'd1: begin
          for (int i = 0; i < IN_DIM; i++) begin
            if (data_in[31:16] == 16'(i)) x_d[i] = data_in[15:0];
          end
        end
        8'd2: begin
          for (int r = 0; r < HID_DIM; r++) begin
            for (int c = 0; c < IN_DIM; c++) begin
              if (data_in[31:24] == 8'(r) && data_in[23:16] == 8'(c)) begin
                w_d[r][c] = data_in[15:0];
              end
            end
          end
        end
        8'd3: begin
          for (int i = 0; i < HID_DIM; i++) begin
            if (data_in[31:16] == 16'(i)) b_d[i] = data_in[15:0];
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_MAC: begin
        acc_d = acc_q + {{8{prod[31]}}, prod};
        if (col_q == COL_W'(IN_DIM - 1)) begin
          col_d   = '0;
          state_d = ST_WB;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_WB: begin
        for (int r = 0; r < HID_DIM; r++) begin
          if (row_q == ROW_W'(r)) h_d[r] = wb_val;
        end
        acc_d = '0;
        if (row_q == ROW_W'(HID_DIM - 1)) begin
          row_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      default: ;
    endcase

    // Registered read; a simultaneous write suppresses the read.
    if (read && !write) begin
      data_out_d = '0;
      if (addr_lo == 8'd0) data_out_d = {30'd0, busy, done_q};
      for (int i = 0; i < HID_DIM; i++) begin
        if ({24'd0, addr_lo} == 32'(16 + i)) begin
          data_out_d = {{16{h_q[i][15]}}, h_q[i]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < IN_DIM; i++) x_q[i] <= '0;
      for (int r = 0; r < HID_DIM; r++) begin
        b_q[r] <= '0;
        h_q[r] <= '0;
        for (int c = 0; c < IN_DIM; c++) w_q[r][c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      x_q        <= x_d;
      w_q        <= w_d;
      b_q        <= b_d;
      h_q        <= h_d;
    end
  end

endmodule

// File: tb/tb_rnn_accel.sv
// Testbench for rnn_accel: directed bus transactions; every read pushes its
// hand-computed expected value into a queue and a monitor process compares
// data_out one step after the clock edge that performs the read.

module tb_rnn_accel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  string       exp_name_q[$];
  logic [31:0] exp_val_q[$];
  string       mon_name;
  logic [31:0] mon_val;

`ifdef RNN_ACCEL_RELU_EN
  localparam logic [31:0] EXP_H1_BASE = 32'd0;
  localparam logic [31:0] EXP_H0_NEG  = 32'd0;
`else
  localparam logic [31:0] EXP_H1_BASE = 32'hFFFF_FFF1;  // -15
  localparam logic [31:0] EXP_H0_NEG  = 32'hFFFF_8000;  // -32768
`endif

  rnn_accel dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: data_out=%h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each read edge produces a data_out value to compare.
  always @(posedge clk) begin
    if (rst_n && read && !write) begin
      #1;
      if (exp_val_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %h expected no read", data_out);
      end else begin
        mon_name = exp_name_q.pop_front();
        mon_val  = exp_val_q.pop_front();
        check(mon_name, data_out, mon_val);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    write   = 1'b1;
    addr    = a;
    data_in = d;
    @(negedge clk);
    write   = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] e, input string name);
    exp_name_q.push_back(name);
    exp_val_q.push_back(e);
    read = 1'b1;
    addr = a;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic wr_x(input int i, input int v);
    do_write(32'd1, {16'(i), 16'(v)});
  endtask

  task automatic wr_w(input int r, input int c, input int v);
    do_write(32'd2, {8'(r), 8'(c), 16'(v)});
  endtask

  task automatic wr_b(input int i, input int v);
    do_write(32'd3, {16'(i), 16'(v)});
  endtask

  task automatic start_and_wait();
    do_write(32'd0, 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic load_base();
    wr_x(0, 2);  wr_x(1, -3); wr_x(2, 0);  wr_x(3, 0);
    wr_w(0, 0, 2); wr_w(0, 1, -10); wr_w(0, 2, -10); wr_w(0, 3, 3);
    wr_w(1, 0, 6); wr_w(1, 1, 9);   wr_w(1, 2, 12);  wr_w(1, 3, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
    #1;
    check("rst_data_out", data_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(32'd0,  32'd0, "rst_status");
    do_read(32'd16, 32'd0, "rst_h0");
    do_read(32'd17, 32'd0, "rst_h1");

    // Base computation with busy/done timing.
    load_base();
    do_write(32'd0, 32'd1);
    for (int k = 0; k < 10; k++) do_read(32'd0, 32'd2, "status_busy");
    do_read(32'd0, 32'd1, "status_done");
    do_read(32'd16, 32'd34, "base_h0");
    do_read(32'd17, EXP_H1_BASE, "base_h1");

    // Read and write together: write wins, data_out holds.
    read = 1'b1; write = 1'b1; addr = 32'd3; data_in = {16'd7, 16'd5};
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    check("rw_hold", data_out, EXP_H1_BASE);
    @(negedge clk);
    check("idle_hold", data_out, EXP_H1_BASE);

    // Out-of-range writes must not alias onto real entries.
    wr_w(5, 0, 777);
    wr_w(0, 9, 777);
    wr_x(4, 50);
    wr_b(2, 50);
    start_and_wait();
    do_read(32'd0,  32'd1,       "oor_done");
    do_read(32'd16, 32'd34,      "oor_h0");
    do_read(32'd17, EXP_H1_BASE, "oor_h1");

    // Bias.
    wr_b(0, 100);
    start_and_wait();
    do_read(32'd16, 32'd134,     "bias_h0");
    do_read(32'd17, EXP_H1_BASE, "bias_h1");

    // Writes and a second start during busy are ignored.
    do_write(32'd0, 32'd1);
    wr_w(1, 0, 1000);
    do_write(32'd0, 32'd1);
    wr_x(0, 7);
    wr_b(0, 0);
    repeat (6) @(negedge clk);
    do_read(32'd0,  32'd1,       "busy_prot_done");
    do_read(32'd16, 32'd134,     "busy_prot_h0");
    do_read(32'd17, EXP_H1_BASE, "busy_prot_h1");

    // Positive saturation.
    for (int c = 0; c < 4; c++) begin
      wr_x(c, 32767);
      wr_w(0, c, 32767);
    end
    start_and_wait();
    do_read(32'd16, 32'd32767, "sat_pos_h0");
    do_read(32'd17, 32'd32767, "sat_pos_h1");

    // Negative saturation.
    wr_b(0, 0);
    wr_w(0, 0, -32768); wr_w(0, 1, 0); wr_w(0, 2, 0); wr_w(0, 3, 0);
    wr_x(1, 0); wr_x(2, 0); wr_x(3, 0);
    start_and_wait();
    do_read(32'd16, EXP_H0_NEG, "sat_neg_h0");
    do_read(32'd17, 32'd32767,  "sat_neg_h1");

    // Asynchronous reset three cycles into a computation.
    do_write(32'd0, 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(32'd0,  32'd0, "midrst_status");
    do_read(32'd16, 32'd0, "midrst_h0");
    do_read(32'd17, 32'd0, "midrst_h1");
    // Weights were cleared: recompute with x loaded only.
    wr_x(0, 2); wr_x(1, -3);
    start_and_wait();
    do_read(32'd0,  32'd1, "midrst_rerun_done");
    do_read(32'd16, 32'd0, "midrst_rerun_h0");
    do_read(32'd17, 32'd0, "midrst_rerun_h1");

    repeat (3) @(negedge clk);
    if (exp_val_q.size() != 0) begin
      n_checks++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", exp_val_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
